// File: rtl/div_arbiter_pkg.sv
// Shared types and constants for the round-robin divider arbiter.
// Holds the FSM state encoding, default sizes and the index-width helper.
package div_arb_pkg;

    localparam int W_DEF    = 8;
    localparam int NREQ_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Bits needed to index n items (n >= 2).
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Requester-side and divider-side signals of the divider arbiter.
// master = arbiter view, slave = requesters plus divider view.
interface div_arbiter_if #(
    parameter int W    = 8,
    parameter int NREQ = 4,
    parameter int IW   = 2
);

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] dvnd_in;
    logic [NREQ*W-1:0] dvsr_in;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      quo_out;
    logic [W-1:0]      rmd_out;
    logic              dz_err;
    logic              busy;
    logic [IW-1:0]     grant_idx;
    logic              div_start;
    logic [W-1:0]      div_dvnd;
    logic [W-1:0]      div_dvsr;
    logic              div_ready;
    logic              div_done_tick;
    logic [W-1:0]      div_quo;
    logic [W-1:0]      div_rmd;

    modport master (
        input  req, dvnd_in, dvsr_in,
        output ack, quo_out, rmd_out, dz_err, busy, grant_idx,
        output div_start, div_dvnd, div_dvsr,
        input  div_ready, div_done_tick, div_quo, div_rmd
    );

    modport slave (
        output req, dvnd_in, dvsr_in,
        input  ack, quo_out, rmd_out, dz_err, busy, grant_idx,
        input  div_start, div_dvnd, div_dvsr,
        output div_ready, div_done_tick, div_quo, div_rmd
    );

endinterface

// File: rtl/div_arbiter_rr_picker.sv
// Rotate-priority encoder: first set request at or after ptr, scanning
// upward modulo NREQ.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   winner,
    output logic            any_req
);

    always_comb begin
        int idx;
        // NOTE: every output gets a value before the loop, so no path
        // through this block leaves one unassigned and no latch is inferred.
        winner  = '0;
        any_req = |req;
        // Scan from the farthest offset down so the nearest one wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) winner = IW'(idx);
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin scheduler sharing one sequential divider among NREQ requesters.
// Optional macro DIV_ZERO_CHECK_EN answers zero-divisor jobs without the divider.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = clog2(NREQ)
) (
    input  logic          clk,
    input  logic          reset,
    div_arbiter_if.master bus
);

`ifdef DIV_ZERO_CHECK_EN
    localparam bit ZERO_CHECK = 1'b1;
`else
    localparam bit ZERO_CHECK = 1'b0;
`endif

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] win_idx;
    logic          any_req;
    logic [W-1:0]  win_dvnd;
    logic [W-1:0]  win_dvsr;
    logic          dz_pend;
    logic [IW-1:0] next_ptr;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req     (bus.req),
        .ptr     (rr_ptr),
        .winner  (win_idx),
        .any_req (any_req)
    );

    assign win_dvnd = bus.dvnd_in[win_idx*W +: W];
    assign win_dvsr = bus.dvsr_in[win_idx*W +: W];
    assign next_ptr = (bus.grant_idx == IW'(NREQ - 1)) ? '0 : bus.grant_idx + 1'b1;

    // NOTE: all state below is sequential, so it is updated with
    // non-blocking assignments; every register then sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            dz_pend       <= 1'b0;
            bus.ack       <= '0;
            bus.quo_out   <= '0;
            bus.rmd_out   <= '0;
            bus.dz_err    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.grant_idx <= '0;
            bus.div_start <= 1'b0;
            bus.div_dvnd  <= '0;
            bus.div_dvsr  <= '0;
        end else begin
            bus.ack       <= '0;
            bus.div_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req && bus.div_ready) begin
                        bus.grant_idx <= win_idx;
                        bus.div_dvnd  <= win_dvnd;
                        bus.div_dvsr  <= win_dvsr;
                        bus.busy      <= 1'b1;
                        // Zero divisor skips the divider and reports from WAIT next cycle.
                        if (ZERO_CHECK && (win_dvsr == '0)) begin
                            dz_pend <= 1'b1;
                            state   <= WAIT;
                        end else begin
                            bus.div_start <= 1'b1;
                            state         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (dz_pend) begin
                        dz_pend     <= 1'b0;
                        bus.quo_out <= '1;
                        bus.rmd_out <= bus.div_dvnd;
                        bus.dz_err  <= 1'b1;
                        bus.ack     <= NREQ'(1) << bus.grant_idx;
                        state       <= RESP;
                    end else if (bus.div_done_tick) begin
                        bus.quo_out <= bus.div_quo;
                        bus.rmd_out <= bus.div_rmd;
                        bus.dz_err  <= 1'b0;
                        bus.ack     <= NREQ'(1) << bus.grant_idx;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr   <= next_ptr;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
